sprite_blitter: RTL and testbench



---
 rtl/sprite_blitter.sv | 207 ++++++++++++++++++++
 tb/tb_sprite_blitter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_blitter.sv
// Palette-indexed, integer-scaled sprite renderer for the VGA scanner, with
// blink-on-select and a fixed three-stage registered output pipeline.
module sprite_blitter #(
    parameter int SPR_W        = 21,
    parameter int SPR_H        = 17,
    parameter int SCALE        = 6,
    parameter int IDX_BITS     = 2,
    parameter int BLINK_FRAMES = 8,
    parameter int BLINK_COUNT  = 3,
    localparam int AW          = $clog2(SPR_W * SPR_H)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [9:0]          x,
    input  logic [8:0]          y,
    input  logic [9:0]          x0,
    input  logic [8:0]          y0,
    input  logic                chosen,
    input  logic                frame_start,
    input  logic                bm_we,
    input  logic [AW-1:0]       bm_addr,
    input  logic [IDX_BITS-1:0] bm_data,
    input  logic                pal_we,
    input  logic [IDX_BITS-1:0] pal_addr,
    input  logic [23:0]         pal_data,
    output logic [7:0]          r,
    output logic [7:0]          g,
    output logic [7:0]          b,
    output logic                hit
);

    localparam int NCELL = SPR_W * SPR_H;
    localparam int NPAL  = 1 << IDX_BITS;
    localparam int FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int TC_W  = $clog2(2 * BLINK_COUNT + 1);
    localparam logic [10:0] WIN_W   = 11'(SPR_W * SCALE);
    localparam logic [10:0] WIN_H   = 11'(SPR_H * SCALE);
    localparam logic [AW:0] NCELL_L = (AW + 1)'(NCELL);
    localparam logic [23:0] WHITE   = 24'hFFFFFF;

    typedef enum logic [1:0] {HIDDEN, BLINK, SHOWN} state_t;

    // Coordinates are widened to 11 bits so origin + extent never wraps.
    function automatic logic in_window(input logic [9:0] px, input logic [9:0] ox,
                                       input logic [8:0] py, input logic [8:0] oy);
        logic [10:0] xe, xo, ye, yo;
        xe = {1'b0, px};
        xo = {1'b0, ox};
        ye = {2'b00, py};
        yo = {2'b00, oy};
        return (xe > xo) && (xe <= xo + WIN_W) && (ye > yo) && (ye <= yo + WIN_H);
    endfunction

    function automatic logic [AW-1:0] cell_addr(input logic [9:0] px, input logic [9:0] ox,
                                                input logic [8:0] py, input logic [8:0] oy);
        logic [10:0] col, row;
        col = ({1'b0, px} - {1'b0, ox} - 11'd1) / 11'(SCALE);
        row = ({2'b00, py} - {2'b00, oy} - 11'd1) / 11'(SCALE);
        return AW'(row * 11'(SPR_W) + col);
    endfunction

    function automatic logic [23:0] pal_default(input int idx);
        case (idx)
            0:       return 24'hFFFFFF;
            1:       return 24'h0F0F0F;
            2:       return 24'h00FFFF;
            3:       return 24'hFFCC00;
            default: return 24'h000000;
        endcase
    endfunction

    state_t            r_state, w_state_nxt;
    logic              r_blink_vis, w_blink_vis_nxt;
    logic [FC_W-1:0]   r_frame_cnt, w_frame_cnt_nxt;
    logic [TC_W-1:0]   r_tog_cnt, w_tog_cnt_nxt;
    logic              r_chosen_d;
    logic              w_visible;

    logic [IDX_BITS-1:0] r_bm [NCELL];
    logic [23:0]         r_pal [NPAL];

    logic                r_vld_p0;
    logic [AW-1:0]       r_addr_p0;
    logic                r_vld_p1;
    logic [IDX_BITS-1:0] r_idx_p1;
    logic                r_hit_p2;
    logic [23:0]         r_rgb_p2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= HIDDEN;
            r_blink_vis <= 1'b0;
            r_frame_cnt <= '0;
            r_tog_cnt   <= '0;
            r_chosen_d  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_blink_vis <= w_blink_vis_nxt;
            r_frame_cnt <= w_frame_cnt_nxt;
            r_tog_cnt   <= w_tog_cnt_nxt;
            r_chosen_d  <= chosen;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_blink_vis_nxt = r_blink_vis;
        w_frame_cnt_nxt = r_frame_cnt;
        w_tog_cnt_nxt   = r_tog_cnt;
        case (r_state)
            HIDDEN: begin
                if (chosen && !r_chosen_d) begin
                    w_state_nxt     = BLINK;
                    w_blink_vis_nxt = 1'b1;
                    w_frame_cnt_nxt = '0;
                    w_tog_cnt_nxt   = '0;
                end
            end
            BLINK: begin
                if (frame_start) begin
                    if (r_frame_cnt == FC_W'(BLINK_FRAMES - 1)) begin
                        w_frame_cnt_nxt = '0;
                        w_blink_vis_nxt = !r_blink_vis;
                        w_tog_cnt_nxt   = r_tog_cnt + TC_W'(1);
                        if (r_tog_cnt == TC_W'(2 * BLINK_COUNT - 1)) begin
                            w_state_nxt = SHOWN;
                        end
                    end else begin
                        w_frame_cnt_nxt = r_frame_cnt + FC_W'(1);
                    end
                end
            end
            SHOWN: begin
                w_blink_vis_nxt = 1'b1;
            end
            default: begin
                w_state_nxt = HIDDEN;
            end
        endcase
        // Deselect wins over everything, including a coincident frame_start.
        if (!chosen) begin
            w_state_nxt     = HIDDEN;
            w_blink_vis_nxt = 1'b0;
        end
    end

    assign w_visible = (r_state == SHOWN) || ((r_state == BLINK) && r_blink_vis);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NPAL; i++) begin
                r_pal[i] <= pal_default(i);
            end
        end else if (pal_we) begin
            r_pal[pal_addr] <= pal_data;
        end
    end

    // S1: window test and cell address
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p0 <= 1'b0;
        end else begin
            r_vld_p0 <= w_visible && in_window(x, x0, y, y0);
        end
    end

    always_ff @(posedge clk) begin
        r_addr_p0 <= cell_addr(x, x0, y, y0);
    end

    // S2: synchronous bitmap read (read-before-write on address collision)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p1 <= 1'b0;
        end else begin
            r_vld_p1 <= r_vld_p0;
        end
    end

    always_ff @(posedge clk) begin
        r_idx_p1 <= r_bm[r_addr_p0];
        if (bm_we && ({1'b0, bm_addr} < NCELL_L)) begin
            r_bm[bm_addr] <= bm_data;
        end
    end

    // S3: palette lookup, index 0 is transparent
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit_p2 <= 1'b0;
            r_rgb_p2 <= WHITE;
        end else if (r_vld_p1 && (r_idx_p1 != '0)) begin
            r_hit_p2 <= 1'b1;
            r_rgb_p2 <= r_pal[r_idx_p1];
        end else begin
            r_hit_p2 <= 1'b0;
            r_rgb_p2 <= WHITE;
        end
    end

    assign r   = r_rgb_p2[23:16];
    assign g   = r_rgb_p2[15:8];
    assign b   = r_rgb_p2[7:0];
    assign hit = r_hit_p2;

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter: a behavioural model checked every cycle,
// plus hand-computed pixel expectations at chosen points.
module tb_sprite_blitter;

    localparam int SPR_W = 21;
    localparam int SPR_H = 17;
    localparam int SCALE = 6;
    localparam int IDX_BITS = 2;
    localparam int BF = 8;
    localparam int BC = 3;
    localparam int AW = 9;
    localparam int NCELL = SPR_W * SPR_H;
    localparam int FS_DONE = 2 * BC * BF;

    logic clk = 1'b0;
    logic rst;
    logic [9:0] x, x0;
    logic [8:0] y, y0;
    logic chosen, frame_start;
    logic bm_we;
    logic [AW-1:0] bm_addr;
    logic [IDX_BITS-1:0] bm_data;
    logic pal_we;
    logic [IDX_BITS-1:0] pal_addr;
    logic [23:0] pal_data;
    logic [7:0] r, g, b;
    logic hit;

    int n_cmp = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    sprite_blitter #(
        .SPR_W(SPR_W), .SPR_H(SPR_H), .SCALE(SCALE), .IDX_BITS(IDX_BITS),
        .BLINK_FRAMES(BF), .BLINK_COUNT(BC)
    ) dut (
        .clk(clk), .rst(rst), .x(x), .y(y), .x0(x0), .y0(y0),
        .chosen(chosen), .frame_start(frame_start),
        .bm_we(bm_we), .bm_addr(bm_addr), .bm_data(bm_data),
        .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
        .r(r), .g(g), .b(b), .hit(hit)
    );

    always #5 clk = ~clk;

    // Behavioural model: visibility from a frame count since selection,
    // pixel colour from plain integer window/cell arithmetic.
    logic [23:0] m_pal [4];
    logic [1:0]  m_bm [NCELL];
    bit          m_active, m_prev;
    int          m_fs;
    bit          m_on1, m_on2;
    int          m_addr1;
    logic [1:0]  m_idx2;
    logic [23:0] exp_rgb;
    logic        exp_hit;

    initial begin
        for (int i = 0; i < NCELL; i++) m_bm[i] = 2'd0;
    end

    function automatic bit vis_f(input bit act, input int fs);
        if (!act) return 1'b0;
        if (fs >= FS_DONE) return 1'b1;
        return ((fs / BF) % 2) == 0;
    endfunction

    function automatic bit win_f(input int px, input int py, input int ox, input int oy);
        int dx, dy;
        dx = px - ox;
        dy = py - oy;
        return dx >= 1 && dx <= SPR_W * SCALE && dy >= 1 && dy <= SPR_H * SCALE;
    endfunction

    function automatic int addr_f(input int px, input int py, input int ox, input int oy);
        if (!win_f(px, py, ox, oy)) return 0;
        return ((py - oy - 1) / SCALE) * SPR_W + (px - ox - 1) / SCALE;
    endfunction

    always @(posedge clk) begin
        if (bm_we && int'(bm_addr) < NCELL) m_bm[bm_addr] <= bm_data;
        if (rst) begin
            m_on1 <= 1'b0;
            m_on2 <= 1'b0;
            exp_rgb <= 24'hFFFFFF;
            exp_hit <= 1'b0;
            m_pal[0] <= 24'hFFFFFF;
            m_pal[1] <= 24'h0F0F0F;
            m_pal[2] <= 24'h00FFFF;
            m_pal[3] <= 24'hFFCC00;
            m_active <= 1'b0;
            m_prev <= 1'b0;
            m_fs <= 0;
        end else begin
            m_on1 <= vis_f(m_active, m_fs) && win_f(int'(x), int'(y), int'(x0), int'(y0));
            m_addr1 <= addr_f(int'(x), int'(y), int'(x0), int'(y0));
            m_on2 <= m_on1;
            m_idx2 <= m_bm[m_addr1];
            if (m_on2 && m_idx2 != 2'd0) begin
                exp_rgb <= m_pal[m_idx2];
                exp_hit <= 1'b1;
            end else begin
                exp_rgb <= 24'hFFFFFF;
                exp_hit <= 1'b0;
            end
            if (pal_we) m_pal[pal_addr] <= pal_data;
            if (!chosen) begin
                m_active <= 1'b0;
            end else if (!m_active && !m_prev) begin
                m_active <= 1'b1;
                m_fs <= 0;
            end else if (m_active && frame_start && m_fs < FS_DONE) begin
                m_fs <= m_fs + 1;
            end
            m_prev <= chosen;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            n_cmp++;
            if ({r, g, b} !== exp_rgb || hit !== exp_hit) begin
                n_fail++;
                $display("FAIL model t=%0t: got rgb=%06h hit=%0b, want rgb=%06h hit=%0b",
                         $time, {r, g, b}, hit, exp_rgb, exp_hit);
            end
        end
    end

    task automatic check_lit(input string nm, input logic [23:0] rgb_e, input logic hit_e);
        n_cmp++;
        if ({r, g, b} !== rgb_e || hit !== hit_e) begin
            n_fail++;
            $display("FAIL %s: got rgb=%06h hit=%0b, want rgb=%06h hit=%0b",
                     nm, {r, g, b}, hit, rgb_e, hit_e);
        end
    endtask

    task automatic probe(input string nm, input logic [9:0] px, input logic [8:0] py,
                         input logic [23:0] rgb_e, input logic hit_e);
        @(negedge clk);
        x = px;
        y = py;
        repeat (3) @(posedge clk);
        #1 check_lit(nm, rgb_e, hit_e);
    endtask

    initial begin
        rst = 1'b1; x = 10'd0; y = 9'd0; x0 = 10'd100; y0 = 9'd50;
        chosen = 1'b0; frame_start = 1'b0;
        bm_we = 1'b0; bm_addr = '0; bm_data = '0;
        pal_we = 1'b0; pal_addr = '0; pal_data = '0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check_lit("reset", 24'hFFFFFF, 1'b0);
        rst = 1'b0;

        // Not chosen: white regardless of scan position.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            x = 10'(95 + i * 7);
            y = 9'(51 + i);
        end
        probe("hidden", 10'd101, 9'd51, 24'hFFFFFF, 1'b0);

        // Checkerboard: even (row+col) -> index 1, odd -> index 2.
        for (int a = 0; a < NCELL; a++) begin
            @(negedge clk);
            bm_we = 1'b1;
            bm_addr = AW'(a);
            bm_data = (((a / SPR_W) + (a % SPR_W)) % 2 == 0) ? 2'd1 : 2'd2;
        end
        @(negedge clk);
        bm_we = 1'b0;
        x = 10'd101;
        y = 9'd51;

        // Blink: one frame_start every 10 cycles.
        chosen = 1'b1;
        for (int f = 0; f < 56; f++) begin
            @(negedge clk); frame_start = 1'b1;
            @(negedge clk); frame_start = 1'b0;
            repeat (4) @(negedge clk);
            if (f == 3 || f == 20 || f == 50) check_lit("blink_on", 24'h0F0F0F, 1'b1);
            if (f == 10 || f == 43) check_lit("blink_off", 24'hFFFFFF, 1'b0);
            repeat (4) @(negedge clk);
        end

        probe("cell00", 10'd101, 9'd51, 24'h0F0F0F, 1'b1);
        probe("cell10", 10'd107, 9'd51, 24'h00FFFF, 1'b1);
        probe("left_edge", 10'd100, 9'd51, 24'hFFFFFF, 1'b0);
        probe("right_out", 10'd227, 9'd51, 24'hFFFFFF, 1'b0);
        probe("last_cell", 10'd226, 9'd152, 24'h0F0F0F, 1'b1);
        probe("last_miss", 10'd227, 9'd152, 24'hFFFFFF, 1'b0);
        probe("row_below", 10'd226, 9'd153, 24'hFFFFFF, 1'b0);
        @(negedge clk); x0 = 10'd1000;
        probe("no_wrap", 10'd5, 9'd51, 24'hFFFFFF, 1'b0);
        @(negedge clk); x0 = 10'd100;
        probe("cell00_again", 10'd101, 9'd51, 24'h0F0F0F, 1'b1);

        // Palette rewrite mid-scan.
        @(negedge clk); pal_we = 1'b1; pal_addr = 2'd1; pal_data = 24'h123456;
        @(negedge clk); pal_we = 1'b0;
        repeat (2) @(negedge clk);
        check_lit("pal_write", 24'h123456, 1'b1);

        // Bitmap write to the cell being read this cycle.
        @(negedge clk); bm_we = 1'b1; bm_addr = '0; bm_data = 2'd2;
        @(negedge clk); bm_we = 1'b0;
        @(posedge clk);
        #1 check_lit("bm_old_read", 24'h123456, 1'b1);
        repeat (2) @(posedge clk);
        #1 check_lit("bm_new_read", 24'h00FFFF, 1'b1);
        @(negedge clk); bm_we = 1'b1; bm_addr = '0; bm_data = 2'd1;
        @(negedge clk); bm_we = 1'b0;
        repeat (4) @(negedge clk);

        // Reset inside an active sprite row.
        rst = 1'b1;
        @(posedge clk);
        #1 check_lit("rst_flush", 24'hFFFFFF, 1'b0);
        @(negedge clk); rst = 1'b0;
        repeat (5) @(negedge clk);
        check_lit("post_rst", 24'h0F0F0F, 1'b1);
        probe("post_rst_cell10", 10'd107, 9'd51, 24'h00FFFF, 1'b1);

        // Into the off half of blink, then drop chosen with a coincident frame_start.
        for (int i = 0; i < 9; i++) begin
            @(negedge clk); frame_start = 1'b1;
            @(negedge clk); frame_start = 1'b0;
        end
        repeat (4) @(negedge clk);
        check_lit("blink_off_half", 24'hFFFFFF, 1'b0);
        chosen = 1'b0; frame_start = 1'b1;
        @(negedge clk); frame_start = 1'b0;
        repeat (3) @(negedge clk);
        check_lit("drop_hidden", 24'hFFFFFF, 1'b0);
        chosen = 1'b1;
        repeat (5) @(negedge clk);
        check_lit("reblink", 24'h00FFFF, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); frame_start = 1'b1;
            @(negedge clk); frame_start = 1'b0;
        end
        repeat (4) @(negedge clk);
        check_lit("reblink_on", 24'h00FFFF, 1'b1);

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
